// File: rtl/register_file_pkg.sv
// register_file_pkg: shared widths, zero constants and word/address types for the register file
package register_file_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDRESS_WIDTH = 5;
  localparam int REGISTER_COUNT = 2 ** ADDRESS_WIDTH;
  typedef logic [ADDRESS_WIDTH-1:0] register_address_t;
  typedef logic [DATA_WIDTH-1:0] data_word_t;
  localparam register_address_t ZERO_REGISTER_ADDRESS = '0;
  localparam data_word_t ZERO_WORD = '0;
endpackage

// File: rtl/register_file_read_port.sv
// register_file_read_port: one read port (reset/enable/r0 gating, optional REGISTER_FILE_BYPASS_EN write-through, stored word)
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = register_file_pkg::ADDRESS_WIDTH,
  parameter int REGISTER_COUNT = register_file_pkg::REGISTER_COUNT
) (
  input  logic                                       reset,
  input  logic [REGISTER_COUNT-1:0][DATA_WIDTH-1:0]  registers,
  input  logic                                       write_enable,
  input  logic [ADDRESS_WIDTH-1:0]                   write_address,
  input  logic [DATA_WIDTH-1:0]                      write_data,
  input  logic                                       read_enable,
  input  logic [ADDRESS_WIDTH-1:0]                   read_address,
  output logic [DATA_WIDTH-1:0]                      read_data
);
  logic bypass_hit;
`ifdef REGISTER_FILE_BYPASS_EN
  assign bypass_hit = write_enable && write_address == read_address;
`else
  assign bypass_hit = 1'b0 & write_enable & (write_address == read_address);
`endif
  always_comb read_data = !reset || !read_enable || read_address == ZERO_REGISTER_ADDRESS ? ZERO_WORD
                        : bypass_hit ? write_data : registers[read_address];
endmodule

// File: rtl/register_file.sv
// register_file: 2R1W GPR file, r0 hardwired 0, async active-low reset; ports clock/reset, wb write triple, two id read ports; REGISTER_FILE_BYPASS_EN enables write-through
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = register_file_pkg::ADDRESS_WIDTH,
  parameter int REGISTER_COUNT = register_file_pkg::REGISTER_COUNT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wb_register_write_enable,
  input  logic [ADDRESS_WIDTH-1:0] wb_register_write_address,
  input  logic [DATA_WIDTH-1:0]    wb_register_write_data,
  input  logic                     id_register_read_enable_1,
  input  logic [ADDRESS_WIDTH-1:0] id_register_read_address_1,
  output logic [DATA_WIDTH-1:0]    id_register_read_data_1,
  input  logic                     id_register_read_enable_2,
  input  logic [ADDRESS_WIDTH-1:0] id_register_read_address_2,
  output logic [DATA_WIDTH-1:0]    id_register_read_data_2
);
  logic [REGISTER_COUNT-1:0][DATA_WIDTH-1:0] registers;
  always_ff @(posedge clock or negedge reset)
    if (!reset) registers <= '0;
    else if (wb_register_write_enable && wb_register_write_address != ZERO_REGISTER_ADDRESS)
      registers[wb_register_write_address] <= wb_register_write_data;
  register_file_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH), .REGISTER_COUNT(REGISTER_COUNT)) port_1 (
    .reset(reset),
    .registers(registers),
    .write_enable(wb_register_write_enable),
    .write_address(wb_register_write_address),
    .write_data(wb_register_write_data),
    .read_enable(id_register_read_enable_1),
    .read_address(id_register_read_address_1),
    .read_data(id_register_read_data_1)
  );
  register_file_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH), .REGISTER_COUNT(REGISTER_COUNT)) port_2 (
    .reset(reset),
    .registers(registers),
    .write_enable(wb_register_write_enable),
    .write_address(wb_register_write_address),
    .write_data(wb_register_write_data),
    .read_enable(id_register_read_enable_2),
    .read_address(id_register_read_address_2),
    .read_data(id_register_read_data_2)
  );
endmodule
